sprite_layer: RTL and testbench

- Parametrised successor of the fixed paddle/ball layer.
- Renders up to NUM_OBJ independent tile sprites. Each sprite has a pixel-accurate position, a tile index, a mirror mode and an enable bit, all read from the shared game-state RAM once per frame.
- For each LCD pixel it selects the highest-priority sprite covering that pixel and fetches the texel from the tile ROM. It then drives the colour plus an active flag to the layer mixer, with a configurable transparent key colour.

---
 rtl/sprite_layer.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_layer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer.sv
// Tile sprite layer: per-frame descriptor load from game-state RAM,
// per-pixel priority select and tile ROM fetch with optional mirroring.
module sprite_layer #(
    parameter int          NUM_OBJ     = 4,
    parameter int          TILE_SHIFT  = 2,
    parameter int          TILE_IDX_W  = 6,
    parameter int          COORD_W     = 9,
    parameter int          RAM_AW      = 5,
    parameter int          RAM_BASE    = 0,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
    localparam int         ROM_AW      = TILE_IDX_W + 2 * TILE_SHIFT,
    localparam int         OBJ_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lcd_clk,
    input  logic                  i_lcd_data_enable,
    input  logic [COORD_W-1:0]    i_x,
    input  logic [COORD_W-1:0]    i_y,
    input  logic [23:0]           i_rom_data,
    input  logic [7:0]            i_ram_data,
    output logic [ROM_AW-1:0]     o_rom_address,
    output logic [RAM_AW-1:0]     o_ram_address,
    output logic [23:0]           o_color,
    output logic                  o_layer_active,
    output logic [OBJ_W-1:0]      o_obj_index,
    output logic                  o_table_busy
);

    localparam int               TS    = 1 << TILE_SHIFT;
    localparam int               CNT_W = $clog2(NUM_OBJ * 4);
    localparam logic [COORD_W:0] TSE   = (COORD_W + 1)'(TS);

    typedef enum logic [2:0] {
        L_IDLE, L_ADDR, L_WAIT, L_READ, L_COMMIT
    } load_t;

    typedef enum logic [2:0] {
        P_IDLE, P_HIT, P_ADDR, P_WAIT, P_DATA
    } pix_t;

    load_t lst;
    pix_t  pst;

    logic [CNT_W-1:0] cnt;
    logic [OBJ_W-1:0] slot;
    logic             de_d;
    logic             lcd_d;
    logic             trig;
    logic             lcd_edge;

    logic [7:0]            sh_x    [NUM_OBJ];
    logic [7:0]            sh_y    [NUM_OBJ];
    logic [TILE_IDX_W-1:0] sh_tile [NUM_OBJ];
    logic [1:0]            sh_mir  [NUM_OBJ];
    logic                  sh_en   [NUM_OBJ];

    logic [7:0]            act_x    [NUM_OBJ];
    logic [7:0]            act_y    [NUM_OBJ];
    logic [TILE_IDX_W-1:0] act_tile [NUM_OBJ];
    logic [1:0]            act_mir  [NUM_OBJ];
    logic                  act_en   [NUM_OBJ];

    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W:0]   cxe, cye;
    logic [NUM_OBJ-1:0] hit;
    logic [OBJ_W-1:0]   win, win_q;
    logic               hit_q;
    logic [TILE_SHIFT-1:0] c, r, cp, rp;
    logic [ROM_AW-1:0]  rom_next;

    assign trig     = i_lcd_data_enable && !de_d && (i_y == '0);
    assign lcd_edge = i_lcd_clk && !lcd_d;
    assign slot     = OBJ_W'(cnt >> 2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lst           <= L_IDLE;
            cnt           <= '0;
            de_d          <= 1'b0;
            o_ram_address <= '0;
            o_table_busy  <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_tile[i]  <= '0;
                sh_mir[i]   <= '0;
                sh_en[i]    <= 1'b0;
                act_x[i]    <= '0;
                act_y[i]    <= '0;
                act_tile[i] <= '0;
                act_mir[i]  <= '0;
                act_en[i]   <= 1'b0;
            end
        end else begin
            de_d <= i_lcd_data_enable;
            unique case (lst)
                L_IDLE: begin
                    if (trig) begin
                        lst           <= L_ADDR;
                        cnt           <= '0;
                        o_ram_address <= RAM_AW'(RAM_BASE);
                        o_table_busy  <= 1'b1;
                    end
                end
                L_ADDR: lst <= L_WAIT;
                L_WAIT: lst <= L_READ;
                L_READ: begin
                    unique case (cnt[1:0])
                        2'd0: sh_x[slot] <= i_ram_data;
                        2'd1: sh_y[slot] <= i_ram_data;
                        2'd2: begin
                            sh_mir[slot]  <= i_ram_data[7:6];
                            sh_tile[slot] <= TILE_IDX_W'(i_ram_data[5:0]);
                        end
                        2'd3: sh_en[slot] <= i_ram_data[7];
                    endcase
                    if (cnt == CNT_W'(NUM_OBJ * 4 - 1)) begin
                        lst <= L_COMMIT;
                    end else begin
                        cnt           <= cnt + 1'b1;
                        o_ram_address <= RAM_AW'(RAM_BASE + int'(cnt) + 1);
                        lst           <= L_ADDR;
                    end
                end
                L_COMMIT: begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        act_x[i]    <= sh_x[i];
                        act_y[i]    <= sh_y[i];
                        act_tile[i] <= sh_tile[i];
                        act_mir[i]  <= sh_mir[i];
                        act_en[i]   <= sh_en[i];
                    end
                    o_table_busy <= 1'b0;
                    lst          <= L_IDLE;
                end
                default: lst <= L_IDLE;
            endcase
        end
    end

    // Extra MSB keeps x+TS from wrapping, so edge sprites are clipped
    assign cxe = {1'b0, cx};
    assign cye = {1'b0, cy};

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        logic [COORD_W:0] xl, yl;
        assign xl     = (COORD_W + 1)'(act_x[g]);
        assign yl     = (COORD_W + 1)'(act_y[g]);
        assign hit[g] = act_en[g] && (cxe >= xl) && (cxe < xl + TSE)
                     && (cye >= yl) && (cye < yl + TSE);
    end

    always_comb begin
        win = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) win = OBJ_W'(i);
        end
    end

    assign c        = TILE_SHIFT'(cx - COORD_W'(act_x[win]));
    assign r        = TILE_SHIFT'(cy - COORD_W'(act_y[win]));
    assign cp       = act_mir[win][1] ? ~c : c;
    assign rp       = act_mir[win][0] ? ~r : r;
    assign rom_next = {act_tile[win], rp, cp};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pst            <= P_IDLE;
            lcd_d          <= 1'b0;
            cx             <= '0;
            cy             <= '0;
            hit_q          <= 1'b0;
            win_q          <= '0;
            o_rom_address  <= '0;
            o_color        <= '0;
            o_layer_active <= 1'b0;
            o_obj_index    <= '0;
        end else begin
            lcd_d <= i_lcd_clk;
            if (lcd_edge) begin
                cx  <= i_x;
                cy  <= i_y;
                pst <= P_HIT;
            end else begin
                unique case (pst)
                    P_IDLE: pst <= P_IDLE;
                    P_HIT: begin
                        hit_q <= |hit;
                        win_q <= win;
                        if (|hit) o_rom_address <= rom_next;
                        pst <= P_ADDR;
                    end
                    P_ADDR: pst <= P_WAIT;
                    P_WAIT: pst <= P_DATA;
                    P_DATA: begin
                        if (hit_q && i_rom_data != TRANSPARENT) begin
                            o_color        <= i_rom_data;
                            o_layer_active <= 1'b1;
                            o_obj_index    <= win_q;
                        end else begin
                            o_color        <= '0;
                            o_layer_active <= 1'b0;
                            o_obj_index    <= '0;
                        end
                        pst <= P_IDLE;
                    end
                    default: pst <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer: RAM/ROM models with 2-cycle latency,
// table of pixel vectors plus hand sequences for load, restart and reset.
module tb_sprite_layer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_lcd_clk = 1'b0;
    logic        i_lcd_data_enable = 1'b0;
    logic [8:0]  i_x = '0;
    logic [8:0]  i_y = 9'd1;
    logic [23:0] i_rom_data = '0;
    logic [7:0]  i_ram_data = '0;
    logic [9:0]  o_rom_address;
    logic [4:0]  o_ram_address;
    logic [23:0] o_color;
    logic        o_layer_active;
    logic [1:0]  o_obj_index;
    logic        o_table_busy;

    sprite_layer dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_lcd_clk         (i_lcd_clk),
        .i_lcd_data_enable (i_lcd_data_enable),
        .i_x               (i_x),
        .i_y               (i_y),
        .i_rom_data        (i_rom_data),
        .i_ram_data        (i_ram_data),
        .o_rom_address     (o_rom_address),
        .o_ram_address     (o_ram_address),
        .o_color           (o_color),
        .o_layer_active    (o_layer_active),
        .o_obj_index       (o_obj_index),
        .o_table_busy      (o_table_busy)
    );

    always #5 i_clk = ~i_clk;

    logic [23:0] rom [1024];
    logic [7:0]  ram [32];
    logic [23:0] rom_q1 = '0;
    logic [7:0]  ram_q1 = '0;

    always @(posedge i_clk) begin
        rom_q1     <= rom[o_rom_address];
        i_rom_data <= rom_q1;
        ram_q1     <= ram[o_ram_address];
        i_ram_data <= ram_q1;
    end

    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rv(input int a);
        return 24'h0A0000 | 24'(a);
    endfunction

    task automatic set_slot(input int n, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] b2,
                            input logic [7:0] b3);
        ram[4 * n]     = x;
        ram[4 * n + 1] = y;
        ram[4 * n + 2] = b2;
        ram[4 * n + 3] = b3;
    endtask

    task automatic load(input bit glitch, output int busy_n,
                        output int addr_err);
        busy_n   = 0;
        addr_err = 0;
        @(negedge i_clk);
        i_y = '0;
        i_lcd_data_enable = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge i_clk);
            if (o_table_busy) begin
                if (busy_n % 3 == 0 && busy_n < 48
                    && int'(o_ram_address) != busy_n / 3)
                    addr_err++;
                if (glitch && busy_n == 10) i_lcd_data_enable = 1'b0;
                if (glitch && busy_n == 12) i_lcd_data_enable = 1'b1;
                busy_n++;
            end else if (busy_n > 0) begin
                break;
            end
        end
        if (glitch) begin
            repeat (5) @(negedge i_clk);
            chk("no_retrigger_busy", o_table_busy, 0);
        end
        i_lcd_data_enable = 1'b0;
        i_y = 9'd1;
    endtask

    task automatic pixel(input int x, input int y, output logic pre_act,
                         output logic [23:0] pre_col);
        @(negedge i_clk);
        i_x = 9'(x);
        i_y = 9'(y);
        i_lcd_clk = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_lcd_clk = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        pre_act = o_layer_active;
        pre_col = o_color;
        @(negedge i_clk);
    endtask

    typedef struct {
        int x;
        int y;
        bit act;
        int idx;
        int addr;
    } vec_t;

    vec_t tv [14];

    initial begin
        int          bn, ae, chg;
        logic        pa;
        logic [23:0] pc;

        for (int a = 0; a < 1024; a++) rom[a] = rv(a);
        for (int a = 0; a < 32; a++) ram[a] = '0;
        set_slot(0, 8'd10,  8'd20, 8'h03, 8'h80);
        set_slot(1, 8'd100, 8'd50, 8'hC5, 8'h80);
        set_slot(2, 8'd254, 8'd30, 8'h47, 8'h80);
        set_slot(3, 8'd12,  8'd22, 8'h09, 8'h80);

        tv[0]  = '{11,  21, 1, 0, 53};
        tv[1]  = '{10,  20, 1, 0, 48};
        tv[2]  = '{13,  23, 1, 0, 63};
        tv[3]  = '{14,  23, 1, 3, 150};
        tv[4]  = '{15,  25, 1, 3, 159};
        tv[5]  = '{16,  25, 0, 0, 0};
        tv[6]  = '{9,   21, 0, 0, 0};
        tv[7]  = '{101, 51, 1, 1, 90};
        tv[8]  = '{103, 50, 1, 1, 92};
        tv[9]  = '{256, 31, 1, 2, 122};
        tv[10] = '{257, 33, 1, 2, 115};
        tv[11] = '{0,   31, 0, 0, 0};
        tv[12] = '{254, 30, 1, 2, 124};
        tv[13] = '{11,  24, 0, 0, 0};

        repeat (3) @(negedge i_clk);
        chk("rst_color", o_color, 0);
        chk("rst_active", o_layer_active, 0);
        chk("rst_index", o_obj_index, 0);
        chk("rst_busy", o_table_busy, 0);
        chk("rst_rom_addr", o_rom_address, 0);
        chk("rst_ram_addr", o_ram_address, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        pixel(11, 21, pa, pc);
        chk("pre_load_active", o_layer_active, 0);

        load(1'b0, bn, ae);
        chk("load_busy_cycles", bn, 49);
        chk("load_addr_seq_errors", ae, 0);

        for (int i = 0; i < 14; i++) begin
            pixel(tv[i].x, tv[i].y, pa, pc);
            if (i == 0) chk("latency_not_early", pa, 0);
            chk($sformatf("vec%0d_active", i), o_layer_active, tv[i].act);
            if (tv[i].act) begin
                chk($sformatf("vec%0d_index", i), o_obj_index, tv[i].idx);
                chk($sformatf("vec%0d_rom_addr", i), o_rom_address,
                    tv[i].addr);
                chk($sformatf("vec%0d_color", i), o_color, rv(tv[i].addr));
            end else begin
                chk($sformatf("vec%0d_color", i), o_color, 0);
            end
        end

        pixel(10, 20, pa, pc);
        chk("restart_base_color", o_color, rv(48));
        @(negedge i_clk);
        i_x = 9'd11;
        i_y = 9'd21;
        i_lcd_clk = 1'b1;
        @(negedge i_clk);
        i_lcd_clk = 1'b0;
        @(negedge i_clk);
        i_x = 9'd101;
        i_y = 9'd51;
        i_lcd_clk = 1'b1;
        chg = 0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge i_clk);
            if (k == 3) i_lcd_clk = 1'b0;
            if (o_color != rv(48)) chg++;
        end
        chk("restart_hold_changes", chg, 0);
        @(negedge i_clk);
        chk("restart_color", o_color, rv(90));
        chk("restart_index", o_obj_index, 1);

        set_slot(0, 8'd10, 8'd20, 8'hC3, 8'h80);
        load(1'b1, bn, ae);
        chk("reload_busy_cycles", bn, 49);
        pixel(11, 21, pa, pc);
        chk("mirror11_rom_addr", o_rom_address, 58);
        chk("mirror11_color", o_color, rv(58));

        set_slot(0, 8'd10, 8'd20, 8'h43, 8'h80);
        load(1'b0, bn, ae);
        pixel(11, 21, pa, pc);
        chk("mirror01_rom_addr", o_rom_address, 57);
        chk("mirror01_color", o_color, rv(57));

        set_slot(0, 8'd10, 8'd20, 8'h03, 8'h80);
        set_slot(1, 8'd11, 8'd21, 8'h04, 8'h80);
        rom[53] = 24'hFF00FF;
        load(1'b0, bn, ae);
        pixel(11, 21, pa, pc);
        chk("transp_active", o_layer_active, 0);
        chk("transp_color", o_color, 0);

        set_slot(0, 8'd10, 8'd20, 8'h03, 8'h7F);
        load(1'b0, bn, ae);
        pixel(11, 21, pa, pc);
        chk("disabled0_active", o_layer_active, 1);
        chk("disabled0_index", o_obj_index, 1);
        chk("disabled0_color", o_color, rv(64));

        @(negedge i_clk);
        i_y = '0;
        i_lcd_data_enable = 1'b1;
        repeat (7) @(negedge i_clk);
        i_x = 9'd11;
        i_y = 9'd21;
        i_lcd_clk = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_color", o_color, 0);
        chk("midrst_active", o_layer_active, 0);
        chk("midrst_index", o_obj_index, 0);
        chk("midrst_busy", o_table_busy, 0);
        chk("midrst_rom_addr", o_rom_address, 0);
        chk("midrst_ram_addr", o_ram_address, 0);
        i_lcd_clk = 1'b0;
        i_lcd_data_enable = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pixel(11, 21, pa, pc);
        chk("after_rst_active", o_layer_active, 0);
        chk("after_rst_busy", o_table_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
